// File: rtl/memory_access_pkg.sv
// Shared definitions for the memory-access stage: pipeline word field
// positions, the memory opcodes, the stage FSM encoding and a helper that
// builds the writeback word for one load-multiple beat.
package memory_access_pkg;

  localparam int PIPE_WORD_W = 41;
  localparam int PIPE_DATA_W = 16;

  // Pipeline word fields
  localparam int F_VALID   = 40;
  localparam int F_DEST_HI = 39;
  localparam int F_DEST_LO = 37;
  localparam int F_MASK_HI = 36;
  localparam int F_MASK_LO = 29;
  localparam int F_OP_HI   = 25;
  localparam int F_OP_LO   = 22;
  localparam int F_RWE     = 21;

  localparam logic [3:0] OP_LW = 4'b0100;
  localparam logic [3:0] OP_SW = 4'b0101;
  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MULTI  = 2'd2
  } ma_state_t;

  // Writeback word for one LM beat: valid, destination register, original
  // mask, LM opcode, register-write enabled, loaded data in the low field.
  function automatic logic [PIPE_WORD_W-1:0] make_lm_word(
    input logic [2:0]             dest,
    input logic [7:0]             mask,
    input logic [PIPE_DATA_W-1:0] data
  );
    logic [PIPE_WORD_W-1:0] w;
    w = '0;
    w[F_VALID]             = 1'b1;
    w[F_DEST_HI:F_DEST_LO] = dest;
    w[F_MASK_HI:F_MASK_LO] = mask;
    w[F_OP_HI:F_OP_LO]     = OP_LM;
    w[F_RWE]               = 1'b1;
    w[PIPE_DATA_W-1:0]     = data;
    return w;
  endfunction

endpackage

// File: rtl/memory_access_if.sv
// Data-memory bus between the memory-access stage (master) and the data
// memory (slave).
//   req   : transaction request, held until ready
//   we    : 1 = write, 0 = read (valid with req)
//   addr  : word address
//   wdata : write data
//   rdata : read data, valid while ready=1
//   ready : transaction accepted/complete this cycle
interface memory_access_if #(
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ready
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ready
  );
endinterface

// File: rtl/memory_access_lm_sm_sequencer.sv
// Register sequencer for load/store-multiple.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   mask     : remaining register mask, mask[7] selects R0 ... mask[0] R7
//   start    : new LM/SM captured; restart the offset count at 0
//   step     : current register serviced; advance the offset
//   next_reg : lowest-numbered register still selected
//   offset   : number of registers already serviced (address offset)
//   last     : exactly one register remains selected
module lm_sm_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] mask,
  input  logic       start,
  input  logic       step,
  output logic [2:0] next_reg,
  output logic [2:0] offset,
  output logic       last
);

  logic [2:0] offset_q;
  logic       found;

  // Priority encoder: mask is MSB-first, so R0 sits in bit 7.
  always_comb begin
    next_reg = '0;
    found    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (mask[7-i] && !found) begin
        next_reg = 3'(i);
        found    = 1'b1;
      end
    end
  end

  // Clearing the lowest set bit leaves zero only for a one-hot mask.
  assign last = (mask != 8'd0) && ((mask & (mask - 8'd1)) == 8'd0);

  always_ff @(posedge clk) begin
    if (rst || start) begin
      offset_q <= '0;
    end else if (step) begin
      offset_q <= offset_q + 3'd1;
    end
  end

  assign offset = offset_q;

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage between the execute->memaccess FIFO and the
// memaccess->writeback FIFO. ALU ops pass through with one cycle of latency,
// LW/SW perform one data-memory transaction, LM/SM perform one transaction
// per register selected in an 8-bit mask. Upstream is stalled while busy.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   instr_in   : pipeline word from the exe_memaccess FIFO
//   st_data    : store data for SW, valid with instr_in
//   rf_rd_addr : register-file read address for SM data
//   rf_rd_data : register-file read data (combinational from rf_rd_addr)
//   mem        : data-memory bus (master side)
//   instr_out  : registered word to the memaccess_wb FIFO
//   stall      : upstream must hold instr_in
module memory_access
  import memory_access_pkg::*;
#(
  parameter int WORD_W = PIPE_WORD_W,
  parameter int DATA_W = PIPE_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] instr_in,
  input  logic [DATA_W-1:0] st_data,
  output logic [2:0]        rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  memory_access_if.master   mem,
  output logic [WORD_W-1:0] instr_out,
  output logic              stall
);

  ma_state_t         state;
  logic [WORD_W-1:0] word_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        mask_q;

  logic              in_valid;
  logic [3:0]        in_op;
  logic [7:0]        in_mask;
  logic              in_single;
  logic              in_multi;
  logic              capture_single;
  logic              capture_multi;

  logic [3:0]        op_q;
  logic              is_sw_q;
  logic              is_sm_q;
  logic [WORD_W-1:0] access_word;

  logic [2:0]        seq_reg;
  logic [2:0]        seq_offset;
  logic              seq_last;
  logic              seq_step;

  assign in_valid  = instr_in[F_VALID];
  assign in_op     = instr_in[F_OP_HI:F_OP_LO];
  assign in_mask   = instr_in[F_MASK_HI:F_MASK_LO];
  assign in_single = (in_op == OP_LW) || (in_op == OP_SW);
  assign in_multi  = (in_op == OP_LM) || (in_op == OP_SM);

  assign capture_single = (state == ST_IDLE) && in_valid && in_single;
  assign capture_multi  = (state == ST_IDLE) && in_valid && in_multi && (in_mask != 8'd0);

  assign op_q    = word_q[F_OP_HI:F_OP_LO];
  assign is_sw_q = (op_q == OP_SW);
  assign is_sm_q = (op_q == OP_SM);

  assign seq_step = (state == ST_MULTI) && mem.ready;

  lm_sm_sequencer u_seq (
    .clk      (clk),
    .rst      (rst),
    .mask     (mask_q),
    .start    (capture_multi),
    .step     (seq_step),
    .next_reg (seq_reg),
    .offset   (seq_offset),
    .last     (seq_last)
  );

  // Completion word for LW/SW: LW returns the loaded data with register
  // write forced on; SW never writes a register.
  always_comb begin
    access_word = word_q;
    if (op_q == OP_LW) begin
      access_word[DATA_W-1:0] = mem.rdata;
      access_word[F_RWE]      = 1'b1;
    end else begin
      access_word[F_RWE]      = 1'b0;
    end
  end

  // Memory bus, register-file read and stall are combinational from the
  // registered state. stall is raised in the capture cycle so the FIFO holds
  // the word, and dropped in the completing cycle so it advances on that edge.
  always_comb begin
    mem.req    = 1'b0;
    mem.we     = 1'b0;
    mem.addr   = '0;
    mem.wdata  = '0;
    rf_rd_addr = '0;
    stall      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        stall = capture_single || capture_multi;
      end
      ST_ACCESS: begin
        mem.req   = 1'b1;
        mem.we    = is_sw_q;
        mem.addr  = word_q[DATA_W-1:0];
        mem.wdata = is_sw_q ? wdata_q : '0;
        stall     = !mem.ready;
      end
      ST_MULTI: begin
        mem.req  = 1'b1;
        mem.we   = is_sm_q;
        // Address wraps modulo 2^DATA_W.
        mem.addr = word_q[DATA_W-1:0] + DATA_W'(seq_offset);
        if (is_sm_q) begin
          rf_rd_addr = seq_reg;
          mem.wdata  = rf_rd_data;
        end
        stall = !(mem.ready && seq_last);
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      instr_out <= '0;
      word_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
    end else begin
      // Every cycle without a result emits a bubble.
      instr_out <= '0;
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (in_single) begin
              word_q  <= instr_in;
              wdata_q <= st_data;
              state   <= ST_ACCESS;
            end else if (in_multi) begin
              if (in_mask != 8'd0) begin
                word_q <= instr_in;
                mask_q <= in_mask;
                state  <= ST_MULTI;
              end
            end else begin
              instr_out <= instr_in;
            end
          end
        end
        ST_ACCESS: begin
          if (mem.ready) begin
            instr_out <= access_word;
            state     <= ST_IDLE;
          end
        end
        ST_MULTI: begin
          if (mem.ready) begin
            mask_q <= mask_q & ~(8'h80 >> seq_reg);
            if (!is_sm_q) begin
              instr_out <= make_lm_word(seq_reg, word_q[F_MASK_HI:F_MASK_LO], mem.rdata);
            end
            if (seq_last) begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [40:0] instr_in;
  logic [15:0] st_data;
  logic [2:0]  rf_rd_addr;
  logic [15:0] rf_rd_data;
  logic [40:0] instr_out;
  logic        stall;

  int errors = 0;
  int checks = 0;
  int ready_delay = 0;
  int wait_cnt = 0;
  int n;

  logic [15:0] tb_mem [0:65535];
  logic [40:0] exp_out [$];
  txn_t        exp_txn [$];

  memory_access_if #(.DATA_W(16)) mif ();

  memory_access dut (
    .clk        (clk),
    .rst        (rst),
    .instr_in   (instr_in),
    .st_data    (st_data),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .mem        (mif),
    .instr_out  (instr_out),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rf_val(input logic [2:0] a);
    return 16'hA000 | {13'd0, a} | ({13'd0, a} << 8);
  endfunction

  function automatic logic [40:0] mk(input logic v, input logic [2:0] dest, input logic [7:0] mask,
                                     input logic [3:0] op, input logic rwe, input logic [15:0] data);
    return {v, dest, mask, 3'b000, op, rwe, 5'b00000, data};
  endfunction

  // Memory model: read data from tb_mem, ready after ready_delay waiting cycles.
  assign rf_rd_data = rf_val(rf_rd_addr);
  assign mif.rdata  = tb_mem[mif.addr];
  assign mif.ready  = (mif.req === 1'b1) && (wait_cnt >= ready_delay);

  always @(posedge clk) begin
    if ((mif.req === 1'b1) && (mif.ready !== 1'b1)) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: writeback words and completed memory transactions.
  always @(negedge clk) begin
    if (instr_out[40] === 1'b1) begin
      checks++;
      assert (exp_out.size() > 0) else begin
        errors++;
        $error("FAIL out_unexpected observed=%h expected=none", instr_out);
      end
      if (exp_out.size() > 0) chk("instr_out", 64'(instr_out), 64'(exp_out.pop_front()));
    end
    if ((mif.req === 1'b1) && (mif.ready === 1'b1)) begin
      checks++;
      assert (exp_txn.size() > 0) else begin
        errors++;
        $error("FAIL txn_unexpected observed=%h expected=none", {mif.we, mif.addr, mif.wdata});
      end
      if (exp_txn.size() > 0) chk("mem_txn", 64'({mif.we, mif.addr, mif.wdata}), 64'(exp_txn.pop_front()));
    end
  end

  // Present a word and hold it while stall is high; returns the stall count.
  task automatic issue(input logic [40:0] w, input logic [15:0] sd, output int cnt);
    instr_in = w;
    st_data  = sd;
    cnt      = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stall !== 1'b1) break;
      cnt++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    instr_in = '0;
    st_data  = '0;
  endtask

  initial begin
    rst = 1'b1;
    instr_in = '0;
    st_data = '0;
    tb_mem[16'h0010] = 16'hBEEF;
    tb_mem[16'hFFFE] = 16'hD000;
    tb_mem[16'hFFFF] = 16'hD001;
    tb_mem[16'h0000] = 16'hD002;
    tb_mem[16'h0200] = 16'hC200;
    tb_mem[16'h0201] = 16'hC201;
    tb_mem[16'h0202] = 16'hC202;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_instr_out", 64'(instr_out), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_req", 64'(mif.req), 64'd0);
    chk("rst_we", 64'(mif.we), 64'd0);
    chk("rst_addr", 64'(mif.addr), 64'd0);
    chk("rst_wdata", 64'(mif.wdata), 64'd0);
    chk("rst_rf_addr", 64'(rf_rd_addr), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ADD passes through in one cycle
    exp_out.push_back(mk(1'b1, 3'd3, 8'h00, 4'b0000, 1'b1, 16'h1234));
    issue(mk(1'b1, 3'd3, 8'h00, 4'b0000, 1'b1, 16'h1234), 16'h0, n);
    chk("add_stall", 64'(n), 64'd0);

    // LW with ready delayed 3 cycles
    ready_delay = 3;
    exp_txn.push_back('{we: 1'b0, addr: 16'h0010, wdata: 16'h0});
    exp_out.push_back(mk(1'b1, 3'd2, 8'h00, 4'b0100, 1'b1, 16'hBEEF));
    issue(mk(1'b1, 3'd2, 8'h00, 4'b0100, 1'b0, 16'h0010), 16'h0, n);
    chk("lw_stall", 64'(n), 64'd4);

    // SW, ready immediately; register write cleared
    ready_delay = 0;
    exp_txn.push_back('{we: 1'b1, addr: 16'h0020, wdata: 16'hA5A5});
    exp_out.push_back(mk(1'b1, 3'd0, 8'h00, 4'b0101, 1'b0, 16'h0020));
    issue(mk(1'b1, 3'd0, 8'h00, 4'b0101, 1'b1, 16'h0020), 16'hA5A5, n);
    chk("sw_stall", 64'(n), 64'd1);

    // LM wrapping past 0xFFFF, R0/R5/R7
    exp_txn.push_back('{we: 1'b0, addr: 16'hFFFE, wdata: 16'h0});
    exp_txn.push_back('{we: 1'b0, addr: 16'hFFFF, wdata: 16'h0});
    exp_txn.push_back('{we: 1'b0, addr: 16'h0000, wdata: 16'h0});
    exp_out.push_back(mk(1'b1, 3'd0, 8'b1000_0101, 4'b0110, 1'b1, 16'hD000));
    exp_out.push_back(mk(1'b1, 3'd5, 8'b1000_0101, 4'b0110, 1'b1, 16'hD001));
    exp_out.push_back(mk(1'b1, 3'd7, 8'b1000_0101, 4'b0110, 1'b1, 16'hD002));
    issue(mk(1'b1, 3'd0, 8'b1000_0101, 4'b0110, 1'b0, 16'hFFFE), 16'h0, n);
    chk("lm_stall", 64'(n), 64'd3);

    // SM with empty mask is a bubble
    issue(mk(1'b1, 3'd0, 8'h00, 4'b0111, 1'b0, 16'h0300), 16'h0, n);
    chk("sm0_stall", 64'(n), 64'd0);

    // SM single register R1
    exp_txn.push_back('{we: 1'b1, addr: 16'h0040, wdata: rf_val(3'd1)});
    issue(mk(1'b1, 3'd0, 8'b0100_0000, 4'b0111, 1'b0, 16'h0040), 16'h0, n);
    chk("sm1_stall", 64'(n), 64'd1);

    // SM R2/R6/R7 with one wait cycle per beat
    ready_delay = 1;
    exp_txn.push_back('{we: 1'b1, addr: 16'h0100, wdata: rf_val(3'd2)});
    exp_txn.push_back('{we: 1'b1, addr: 16'h0101, wdata: rf_val(3'd6)});
    exp_txn.push_back('{we: 1'b1, addr: 16'h0102, wdata: rf_val(3'd7)});
    issue(mk(1'b1, 3'd0, 8'b0010_0011, 4'b0111, 1'b0, 16'h0100), 16'h0, n);
    chk("sm3_stall", 64'(n), 64'd6);

    // Reset in the middle of an LM after the first beat
    ready_delay = 0;
    exp_txn.push_back('{we: 1'b0, addr: 16'h0200, wdata: 16'h0});
    exp_out.push_back(mk(1'b1, 3'd0, 8'b1110_0000, 4'b0110, 1'b1, 16'hC200));
    instr_in = mk(1'b1, 3'd0, 8'b1110_0000, 4'b0110, 1'b0, 16'h0200);
    @(negedge clk);
    chk("lmr_capture_stall", 64'(stall), 64'd1);
    @(posedge clk); #1;
    instr_in = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_txn.push_back('{we: 1'b0, addr: 16'h0201, wdata: 16'h0});
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_instr_out", 64'(instr_out), 64'd0);
    chk("abort_stall", 64'(stall), 64'd0);
    chk("abort_req", 64'(mif.req), 64'd0);
    chk("abort_we", 64'(mif.we), 64'd0);
    chk("abort_addr", 64'(mif.addr), 64'd0);
    chk("abort_wdata", 64'(mif.wdata), 64'd0);
    chk("abort_rf_addr", 64'(rf_rd_addr), 64'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("abort_idle_req", 64'(mif.req), 64'd0);
    chk("out_queue_left", 64'(exp_out.size()), 64'd0);
    chk("txn_queue_left", 64'(exp_txn.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
